// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared constants and FSM state type for the cellular automaton display
package ca_pkg;

    localparam int CA_ROWS  = 60;
    localparam int CA_COLS  = 80;
    localparam int CA_ROW_W = 7;
    localparam int CA_COL_W = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_PEND = 2'd2
    } ca_state_e;

endpackage

// File: rtl/ca_row_bank.sv
// rtl/ca_row_bank.sv - ROWS x COLS row store, one row write, registered row and cell reads
module ca_row_bank #(
    parameter int ROWS  = 60,
    parameter int COLS  = 80,
    parameter int ROW_W = 7,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [COLS-1:0]  wdata,
    input  logic [ROW_W-1:0] row_addr,
    output logic [COLS-1:0]  row_data,
    input  logic [ROW_W-1:0] cell_row,
    input  logic [COL_W-1:0] cell_col,
    output logic             cell_data
);

    localparam int AW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [COLS-1:0] mem [ROWS];

    logic [AW-1:0] wa, ra, ca_r;
    logic [CW-1:0] ca_c;
    logic          row_ok, cell_ok;

    assign wa      = waddr[AW-1:0];
    assign ra      = row_addr[AW-1:0];
    assign ca_r    = cell_row[AW-1:0];
    assign ca_c    = cell_col[CW-1:0];
    assign row_ok  = (row_addr <= ROW_LAST);
    assign cell_ok = (cell_row <= ROW_LAST) && (cell_col <= COL_LAST);

    // Writers guarantee waddr is in range, so no guard is needed here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data  <= '0;
            cell_data <= 1'b0;
        end else begin
            row_data  <= row_ok  ? mem[ra]       : '0;
            cell_data <= cell_ok ? mem[ca_r][ca_c] : 1'b0;
        end
    end

endmodule

// File: rtl/ca_gen_buffer.sv
// rtl/ca_gen_buffer.sv - ping-pong generation store with frame-aligned swap and row clear
module ca_gen_buffer
    import ca_pkg::*;
#(
    parameter int ROWS  = CA_ROWS,
    parameter int COLS  = CA_COLS,
    parameter int ROW_W = CA_ROW_W,
    parameter int COL_W = CA_COL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] pix_row,
    input  logic [COL_W-1:0] pix_col,
    output logic             pix_data,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    output logic             wr_err,
    input  logic             clear_req,
    input  logic             swap_req,
    input  logic             frame_sync,
    output logic             swap_ack,
    output logic             busy,
    output logic             front_sel
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    ca_state_e        state, state_d;
    logic [ROW_W-1:0] clr_cnt, clr_cnt_d;
    logic             pend, pend_d;
    logic             toggle;
    logic             rd_sel;

    logic             clearing, wr_ok, bank_we;
    logic [ROW_W-1:0] bank_waddr;
    logic [COLS-1:0]  bank_wdata;
    logic [COLS-1:0]  row0, row1;
    logic             cell0, cell1;

    assign clearing   = (state == CLEAR);
    assign wr_ok      = wr_en && (wr_row <= ROW_LAST) && !clearing;
    assign bank_we    = wr_ok || clearing;
    assign bank_waddr = clearing ? clr_cnt : wr_row;
    assign bank_wdata = clearing ? '0 : wr_data;
    assign busy       = (state != IDLE);

    always_comb begin
        state_d   = state;
        clr_cnt_d = clr_cnt;
        pend_d    = pend;
        toggle    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    pend_d    = swap_req;
                end else if (swap_req) begin
                    state_d = SWAP_PEND;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt + ROW_W'(1);
                pend_d    = pend || swap_req;
                if (clr_cnt == ROW_LAST) begin
                    state_d   = (pend || swap_req) ? SWAP_PEND : IDLE;
                    pend_d    = 1'b0;
                    clr_cnt_d = '0;
                end
            end
            SWAP_PEND: begin
                // A clear restarts from row 0 but the requested swap still follows it.
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    pend_d    = 1'b1;
                end else if (frame_sync) begin
                    toggle  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            pend      <= 1'b0;
            front_sel <= 1'b0;
            swap_ack  <= 1'b0;
            wr_err    <= 1'b0;
            rd_sel    <= 1'b0;
        end else begin
            state     <= state_d;
            clr_cnt   <= clr_cnt_d;
            pend      <= pend_d;
            front_sel <= front_sel ^ toggle;
            swap_ack  <= toggle;
            wr_err    <= wr_en && !wr_ok;
            rd_sel    <= front_sel;
        end
    end

    // rd_sel remembers which bank was FRONT when the read was issued.
    assign pix_data = rd_sel ? cell1 : cell0;
    assign rd_data  = rd_sel ? row1  : row0;

    ca_row_bank #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bank_we && front_sel),
        .waddr     (bank_waddr),
        .wdata     (bank_wdata),
        .row_addr  (rd_row),
        .row_data  (row0),
        .cell_row  (pix_row),
        .cell_col  (pix_col),
        .cell_data (cell0)
    );

    ca_row_bank #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bank_we && !front_sel),
        .waddr     (bank_waddr),
        .wdata     (bank_wdata),
        .row_addr  (rd_row),
        .row_data  (row1),
        .cell_row  (pix_row),
        .cell_col  (pix_col),
        .cell_data (cell1)
    );

endmodule

// File: tb/tb_ca_gen_buffer.sv
// tb/tb_ca_gen_buffer.sv - self-checking bench for ca_gen_buffer against a bank-array model
module tb_ca_gen_buffer;

    localparam int ROWS = 60;
    localparam int COLS = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  pix_row = '0;
    logic [6:0]  pix_col = '0;
    logic        pix_data;
    logic [6:0]  rd_row = '0;
    logic [79:0] rd_data;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_row = '0;
    logic [79:0] wr_data = '0;
    logic        wr_err;
    logic        clear_req = 1'b0;
    logic        swap_req = 1'b0;
    logic        frame_sync = 1'b0;
    logic        swap_ack;
    logic        busy;
    logic        front_sel;

    int          total = 0;
    int          bad = 0;
    logic [79:0] mdl [2][ROWS];
    int          mfront = 0;
    int          n;
    int          wrows [3];

    always #5 clk = ~clk;

    ca_gen_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .pix_data   (pix_data),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .clear_req  (clear_req),
        .swap_req   (swap_req),
        .frame_sync (frame_sync),
        .swap_ack   (swap_ack),
        .busy       (busy),
        .front_sel  (front_sel)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [79:0] rnd80();
        return 80'({$urandom, $urandom, $urandom});
    endfunction

    function automatic logic [79:0] exp_row(input int f, input int r);
        if (r >= ROWS) return '0;
        return mdl[f][r];
    endfunction

    function automatic logic exp_pix(input int f, input int r, input int c);
        logic [79:0] w;
        if (r >= ROWS || c >= COLS) return 1'b0;
        w = mdl[f][r];
        return w[c];
    endfunction

    task automatic write_row(input int r, input logic [79:0] d, input logic expect_err);
        wr_en = 1'b1;
        wr_row = 7'(r);
        wr_data = d;
        cycle();
        wr_en = 1'b0;
        chk("wr_err", 80'(wr_err), 80'(expect_err));
        if (!expect_err && r < ROWS) mdl[1 - mfront][r] = d;
    endtask

    task automatic read_chk(input int r, input int c, input int rr);
        logic        ep;
        logic [79:0] er;
        pix_row = 7'(r);
        pix_col = 7'(c);
        rd_row = 7'(rr);
        ep = exp_pix(mfront, r, c);
        er = exp_row(mfront, rr);
        cycle();
        if (!$isunknown(ep)) chk("pix_data", 80'(pix_data), 80'(ep));
        if (!$isunknown(er)) chk("rd_data", rd_data, er);
    endtask

    // Optional swap_req, some idle cycles, then a frame_sync; the read issued
    // in the toggle cycle must still come from the old FRONT bank.
    task automatic do_swap(input logic req, input int waits, input int rr);
        logic [79:0] er;
        if (req) begin
            swap_req = 1'b1;
            cycle();
            swap_req = 1'b0;
            chk("swap_busy", 80'(busy), 80'(1));
        end
        for (int i = 0; i < waits; i++) begin
            swap_req = (i == 1);
            cycle();
            chk("pend_busy", 80'(busy), 80'(1));
            chk("pend_front", 80'(front_sel), 80'(mfront));
        end
        swap_req = 1'b0;
        frame_sync = 1'b1;
        rd_row = 7'(rr);
        er = exp_row(mfront, rr);
        cycle();
        frame_sync = 1'b0;
        chk("swap_ack", 80'(swap_ack), 80'(1));
        chk("front_toggle", 80'(front_sel), 80'(1 - mfront));
        if (!$isunknown(er)) chk("toggle_read_old", rd_data, er);
        mfront = 1 - mfront;
        cycle();
        chk("swap_ack_pulse", 80'(swap_ack), 80'(0));
        chk("swap_idle", 80'(busy), 80'(0));
        chk("front_hold", 80'(front_sel), 80'(mfront));
    endtask

    // Clear with an illegal write at err_at and a stray frame_sync at fs_at.
    task automatic do_clear(input logic with_swap, input int err_at, input int fs_at);
        int cnt;
        clear_req = 1'b1;
        swap_req = with_swap;
        cycle();
        clear_req = 1'b0;
        swap_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (busy) cnt++;
            wr_en = (i == err_at);
            wr_row = 7'(i % ROWS);
            wr_data = rnd80();
            frame_sync = (i == fs_at);
            clear_req = (i == 5);
            cycle();
            wr_en = 1'b0;
            frame_sync = 1'b0;
            clear_req = 1'b0;
            if (i == err_at) chk("clear_wr_err", 80'(wr_err), 80'(1));
            if (i == fs_at) chk("clear_fs_noack", 80'(swap_ack), 80'(0));
        end
        chk("clear_len", 80'(cnt), 80'(ROWS));
        chk("clear_after_busy", 80'(busy), 80'(with_swap));
        chk("clear_front", 80'(front_sel), 80'(mfront));
        for (int r = 0; r < ROWS; r++) mdl[1 - mfront][r] = '0;
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) mdl[b][r] = 'x;

        // Reset state
        repeat (3) cycle();
        chk("rst_pix", 80'(pix_data), 80'(0));
        chk("rst_rd", rd_data, 80'(0));
        chk("rst_wr_err", 80'(wr_err), 80'(0));
        chk("rst_ack", 80'(swap_ack), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        chk("rst_front", 80'(front_sel), 80'(0));
        rst_n = 1'b1;
        cycle();

        // Row 5 = 1 plus random rows into BACK, then swap and read back
        write_row(5, 80'h1, 1'b0);
        for (int k = 0; k < 4; k++) write_row($urandom_range(10, ROWS - 1), rnd80(), 1'b0);
        do_swap(1'b1, 1, 5);
        read_chk(5, 0, 5);
        chk("t1_row5", rd_data, 80'h1);
        for (int k = 0; k < 8; k++) read_chk($urandom_range(0, 63), $urandom_range(0, 83), $urandom_range(5, 63));

        // Swap waits for frame_sync; a later frame_sync changes nothing
        do_swap(1'b1, 3, 5);
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        chk("extra_fs_ack", 80'(swap_ack), 80'(0));
        chk("extra_fs_front", 80'(front_sel), 80'(mfront));

        // Clear, then every row of the new FRONT reads as zero
        do_clear(1'b0, 10, 30);
        do_swap(1'b1, 0, 0);
        for (int r = 0; r < ROWS; r++) read_chk(r, $urandom_range(0, COLS - 1), r);

        // Clear and swap together: swap waits for the clear, writes in SWAP_PEND land
        do_clear(1'b1, 50, 30);
        for (int k = 0; k < 3; k++) begin
            wrows[k] = $urandom_range(0, ROWS - 1);
            write_row(wrows[k], rnd80(), 1'b0);
        end
        chk("pend_after_writes", 80'(busy), 80'(1));
        do_swap(1'b0, 2, wrows[0]);
        for (int k = 0; k < 3; k++) read_chk(wrows[k], $urandom_range(0, COLS - 1), wrows[k]);

        // Out-of-range addresses
        write_row(60, rnd80(), 1'b1);
        write_row(127, rnd80(), 1'b1);
        chk("oor_front", 80'(front_sel), 80'(mfront));
        read_chk(60, 0, 60);
        chk("oor_pix_row", 80'(pix_data), 80'(0));
        read_chk(wrows[0], 80, 127);
        chk("oor_pix_col", 80'(pix_data), 80'(0));
        read_chk(wrows[1], 79, 59);
        for (int k = 0; k < 20; k++) read_chk($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));

        // Reset in the middle of a clear with a pending swap
        clear_req = 1'b1;
        swap_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        swap_req = 1'b0;
        repeat (20) cycle();
        read_chk(wrows[2], 3, wrows[2]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pix", 80'(pix_data), 80'(0));
        chk("mid_rst_rd", rd_data, 80'(0));
        chk("mid_rst_wr_err", 80'(wr_err), 80'(0));
        chk("mid_rst_ack", 80'(swap_ack), 80'(0));
        chk("mid_rst_busy", 80'(busy), 80'(0));
        chk("mid_rst_front", 80'(front_sel), 80'(0));
        cycle();
        rst_n = 1'b1;
        mfront = 0;
        cycle();
        frame_sync = 1'b1;
        cycle();
        frame_sync = 1'b0;
        chk("post_rst_noack", 80'(swap_ack), 80'(0));
        chk("post_rst_front", 80'(front_sel), 80'(0));
        chk("post_rst_busy", 80'(busy), 80'(0));
        for (int k = 0; k < 3; k++) read_chk(wrows[k], $urandom_range(0, COLS - 1), wrows[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
